data_mem_hs: RTL

DATA_MEM_HS -- requirements
Module: data_mem_hs

---
 rtl/data_mem_hs.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with a valid/ready request/response handshake,
// a fixed access latency, alignment checking and load sign/zero extension.
module data_mem_hs #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic        we_q;
    logic        zext_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] rd_word_q;

    logic [7:0]  mem [DEPTH];

    logic                  accept;
    logic                  misaligned;
    logic                  do_write;
    logic                  do_read;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [3:0]            byte_en;
    logic [31:0]           wr_lanes;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           ext_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];

    assign accept   = req_valid && ready_q;
    assign word_idx = req_addr[ADDR_WIDTH-1:2];
    assign do_write = accept && req_we && !misaligned;
    assign do_read  = accept && !req_we && !misaligned;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wr_lanes   = '0;
        case (req_ctrl[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                byte_en    = 4'b0011 << req_addr[1:0];
                wr_lanes   = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |req_addr[1:0];
                byte_en    = 4'b1111;
                wr_lanes   = req_wdata;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Aligned accesses stay inside one 4-byte group, so all lanes share word_idx.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (do_write && byte_en[l]) begin
                mem[{word_idx, 2'(l)}] <= wr_lanes[8*l +: 8];
            end
            if (do_read) begin
                rd_word_q[8*l +: 8] <= mem[{word_idx, 2'(l)}];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            zext_q  <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        err_q   <= misaligned;
                        we_q    <= req_we;
                        zext_q  <= req_ctrl[2];
                        size_q  <= req_ctrl[1:0];
                        off_q   <= req_addr[1:0];
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Extension works on the word captured at accept, so the response is stable while held.
    always_comb begin
        byte_sel = rd_word_q[{off_q, 3'b000} +: 8];
        half_sel = rd_word_q[{off_q[1], 4'b0000} +: 16];
        ext_data = rd_word_q;
        case (size_q)
            2'b00:   ext_data = zext_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = zext_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ext_data = rd_word_q;
        endcase
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = valid_q && err_q;
    assign resp_rdata = (valid_q && !err_q && !we_q) ? ext_data : 32'd0;

endmodule
